// File: rtl/seq_div_sixteen_eight.sv
// Iterative restoring divider: NW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Define SELFCHK_EN to add the chk_err port and a Q*D+R back-check at completion.
module seq_div_sixteen_eight #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          dz
`ifdef SELFCHK_EN
    ,
    output logic          chk_err
`endif
);

    localparam int CW = $clog2(NW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    logic [DW:0]   pr;
    logic [CW-1:0] cnt;

    logic [DW:0]   shifted;
    logic [DW:0]   diff;
    logic          qbit;
    logic [DW:0]   pr_next;
    logic [NW-1:0] q_next;

    // One restoring step; the partial remainder never exceeds 2*D-1, so DW+1 bits suffice.
    always_comb begin
        shifted = {pr[DW-1:0], n[NW-1]};
        diff    = shifted - {1'b0, d};
        qbit    = (shifted >= {1'b0, d});
        pr_next = qbit ? diff : shifted;
        q_next  = {Q[NW-2:0], qbit};
    end

`ifdef SELFCHK_EN
    logic [NW-1:0]    n_orig;
    logic [NW+DW-1:0] product;
    logic             chk_fail;

    always_comb begin
        product  = (NW+DW)'(q_next) * (NW+DW)'(d) + (NW+DW)'(pr_next[DW-1:0]);
        chk_fail = (product != (NW+DW)'(n_orig)) || (pr_next[DW-1:0] >= d);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n     <= '0;
            d     <= '0;
            pr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            dz    <= 1'b0;
`ifdef SELFCHK_EN
            n_orig  <= '0;
            chk_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n    <= N;
                        d    <= D;
                        pr   <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef SELFCHK_EN
                        n_orig  <= N;
                        chk_err <= 1'b0;
`endif
                        if (D == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            Q     <= '1;
                            R     <= N[DW-1:0];
                            dz    <= 1'b1;
                        end else begin
                            state <= RUN;
                            Q     <= '0;
                            R     <= '0;
                            dz    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    pr  <= pr_next;
                    n   <= {n[NW-2:0], 1'b0};
                    Q   <= q_next;
                    R   <= pr_next[DW-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NW-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
`ifdef SELFCHK_EN
                        chk_err <= chk_fail;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_sixteen_eight.sv
// Directed and random checks for seq_div_sixteen_eight; chk_err is also checked when SELFCHK_EN is defined.
module tb_seq_div_sixteen_eight;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dz;
`ifdef SELFCHK_EN
    logic        chk_err;
`endif

    int checks = 0;
    int failures = 0;

    seq_div_sixteen_eight #(.NW(16), .DW(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .N     (dividend),
        .D     (divisor),
        .busy  (busy),
        .done  (done),
        .Q     (quotient),
        .R     (remainder),
        .dz    (dz)
`ifdef SELFCHK_EN
        ,
        .chk_err (chk_err)
`endif
    );

    always #5 clk = ~clk;

    // Pulses start for one edge and waits (bounded) for done; returns at the negedge where done is seen.
    task automatic run_op(input logic [15:0] n_val, input logic [7:0] d_val,
                          output int cycles, output int busy_cycles, output bit timed_out);
        @(negedge clk);
        dividend = n_val;
        divisor  = d_val;
        start    = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        cycles      = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, dz} !== 27'd0) begin
            failures++;
            $display("[TB] FAIL reset: busy=%b done=%b Q=%h R=%h dz=%b, required all 0",
                     busy, done, quotient, remainder, dz);
        end
`ifdef SELFCHK_EN
        checks++;
        if (chk_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_chk_err: got %b, required 0", chk_err);
        end
`endif
    endtask

    task automatic test_max();
        int cyc, bcyc;
        bit to;
        run_op(16'hFFFF, 8'hFF, cyc, bcyc, to);
        checks++;
        if (to || cyc != 17) begin
            failures++;
            $display("[TB] FAIL max_latency: done at cycle %0d (timeout=%0d), required 17", cyc, to);
        end
        checks++;
        if ({quotient, remainder, dz} !== {16'h0101, 8'h00, 1'b0}) begin
            failures++;
            $display("[TB] FAIL max_result: Q=%h R=%h dz=%b, required Q=0101 R=00 dz=0",
                     quotient, remainder, dz);
        end
    endtask

    task automatic test_busy_window();
        int cyc, bcyc;
        bit to;
        run_op(16'd1000, 8'd7, cyc, bcyc, to);
        checks++;
        if (to || quotient !== 16'd142 || remainder !== 8'd6) begin
            failures++;
            $display("[TB] FAIL div_1000_7: Q=%0d R=%0d timeout=%0d, required Q=142 R=6",
                     quotient, remainder, to);
        end
        @(negedge clk);
        checks++;
        if (bcyc != 17 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_window: busy cycles=%0d then busy=%b done=%b, required 17 then 0 0",
                     bcyc, busy, done);
        end
    endtask

    task automatic test_div_zero();
        int cyc, bcyc;
        bit to;
        run_op(16'h1234, 8'h00, cyc, bcyc, to);
        checks++;
        if (to || cyc != 1 || {quotient, remainder, dz} !== {16'hFFFF, 8'h34, 1'b1}) begin
            failures++;
            $display("[TB] FAIL div_zero: cycle=%0d Q=%h R=%h dz=%b, required cycle 1 Q=FFFF R=34 dz=1",
                     cyc, quotient, remainder, dz);
        end
`ifdef SELFCHK_EN
        checks++;
        if (chk_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL div_zero_chk_err: got %b, required 0", chk_err);
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {quotient, remainder, dz} !== {16'hFFFF, 8'h34, 1'b1}) begin
            failures++;
            $display("[TB] FAIL div_zero_hold: done=%b busy=%b Q=%h R=%h dz=%b, required 0 0 FFFF 34 1",
                     done, busy, quotient, remainder, dz);
        end
    endtask

    task automatic test_small();
        int cyc, bcyc;
        bit to;
        run_op(16'd5, 8'd9, cyc, bcyc, to);
        checks++;
        if (to || quotient !== 16'd0 || remainder !== 8'd5 || dz !== 1'b0) begin
            failures++;
            $display("[TB] FAIL div_5_9: Q=%0d R=%0d dz=%b, required Q=0 R=5 dz=0", quotient, remainder, dz);
        end
        run_op(16'd0, 8'd1, cyc, bcyc, to);
        checks++;
        if (to || quotient !== 16'd0 || remainder !== 8'd0) begin
            failures++;
            $display("[TB] FAIL div_0_1: Q=%0d R=%0d, required Q=0 R=0", quotient, remainder);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc = 1;
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 40) begin
            if (cyc == 4) begin
                dividend = 16'hBEEF;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc != 17 || quotient !== 16'd142 || remainder !== 8'd6) begin
            failures++;
            $display("[TB] FAIL start_ignored: cycle=%0d Q=%0d R=%0d, required cycle 17 Q=142 R=6",
                     cyc, quotient, remainder);
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        int cyc, bcyc;
        bit to;
        @(negedge clk);
        dividend = 16'hABCD;
        divisor  = 8'h13;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, dz} !== 27'd0) begin
            failures++;
            $display("[TB] FAIL abort_clear: busy=%b done=%b Q=%h R=%h dz=%b, required all 0",
                     busy, done, quotient, remainder, dz);
        end
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("[TB] FAIL abort_no_done: done seen %0d times, required 0", done_seen);
        end
        run_op(16'd50000, 8'd200, cyc, bcyc, to);
        checks++;
        if (to || cyc != 17 || quotient !== 16'd250 || remainder !== 8'd0) begin
            failures++;
            $display("[TB] FAIL after_abort: cycle=%0d Q=%0d R=%0d, required cycle 17 Q=250 R=0",
                     cyc, quotient, remainder);
        end
    endtask

    task automatic test_random();
        int cyc, bcyc;
        bit to;
        logic [15:0] n_val, exp_q;
        logic [7:0]  d_val, exp_r;
        for (int i = 0; i < 2000; i++) begin
            n_val = 16'($urandom);
            d_val = 8'($urandom_range(1, 255));
            exp_q = n_val / 16'(d_val);
            exp_r = 8'(n_val % 16'(d_val));
            run_op(n_val, d_val, cyc, bcyc, to);
            checks++;
            if (to || quotient !== exp_q || remainder !== exp_r || dz !== 1'b0) begin
                failures++;
                $display("[TB] FAIL random %0d/%0d: Q=%0d R=%0d dz=%b, required Q=%0d R=%0d dz=0",
                         n_val, d_val, quotient, remainder, dz, exp_q, exp_r);
            end
`ifdef SELFCHK_EN
            checks++;
            if (chk_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL random_chk_err %0d/%0d: got %b, required 0", n_val, d_val, chk_err);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_busy_window();
        test_div_zero();
        test_small();
        test_start_while_busy();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
